// File: rtl/uart_block_tx_arbiter.sv
// Round-robin arbiter sharing one 128-bit block UART transmit channel
// between NREQ producers, with a watchdog on the transceiver's tx_done.
module uart_block_tx_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*128-1:0] req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     req_done,
    output logic [127:0]        tx_data,
    output logic                tx_wr,
    input  logic                tx_done,
    output logic                busy,
    output logic [2:0]          grant_id,
    output logic                timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [2:0]      last_grant_q, last_grant_d;
    logic [31:0]     wdog_q, wdog_d;
    logic [127:0]    tx_data_q, tx_data_d;
    logic            tx_wr_q, tx_wr_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [NREQ-1:0] req_done_q, req_done_d;
    logic            busy_q, busy_d;
    logic [2:0]      grant_id_q, grant_id_d;
    logic            timeout_err_q, timeout_err_d;

    // Requests and blocks padded to 8 slots so a 3-bit index always fits.
    logic [7:0]   valid_pad;
    logic [127:0] blk [8];

    assign valid_pad = 8'(req_valid);

    for (genvar i = 0; i < 8; i++) begin : g_blk
        if (i < NREQ) begin : g_on
            assign blk[i] = req_data[i*128 +: 128];
        end else begin : g_off
            assign blk[i] = '0;
        end
    end

    logic       pick_found;
    logic [2:0] pick_idx;
    logic [3:0] cand;
    logic [7:0] ready_sel;
    logic [7:0] done_sel;
    logic       wdog_expired;

    // Rotating priority search starting just after the last served requester.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_grant_q} + 4'(k);
            if (cand >= 4'(NREQ)) begin
                cand = cand - 4'(NREQ);
            end
            if (!pick_found && valid_pad[cand[2:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[2:0];
            end
        end
    end

    assign ready_sel = 8'(1) << pick_idx;
    assign done_sel  = 8'(1) << grant_id_q;

    // Disabled watchdog (TIMEOUT_CYCLES == 0) can never expire.
    assign wdog_expired = (TIMEOUT_CYCLES != 0) &&
                          (wdog_q == 32'(TIMEOUT_CYCLES - 1));

    // Next-state and registered-output logic; pulses default low.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        wdog_d        = wdog_q;
        tx_data_d     = tx_data_q;
        tx_wr_d       = 1'b0;
        req_ready_d   = '0;
        req_done_d    = '0;
        busy_d        = busy_q;
        grant_id_d    = grant_id_q;
        timeout_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    tx_data_d   = blk[pick_idx];
                    grant_id_d  = pick_idx;
                    req_ready_d = ready_sel[NREQ-1:0];
                    tx_wr_d     = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    req_done_d   = done_sel[NREQ-1:0];
                    last_grant_d = grant_id_q;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end else if (wdog_expired) begin
                    timeout_err_d = 1'b1;
                    last_grant_d  = grant_id_q;
                    busy_d        = 1'b0;
                    state_d       = S_IDLE;
                end else if (wdog_q != '1) begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 3'(NREQ - 1);
            wdog_q        <= '0;
            tx_data_q     <= '0;
            tx_wr_q       <= 1'b0;
            req_ready_q   <= '0;
            req_done_q    <= '0;
            busy_q        <= 1'b0;
            grant_id_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            wdog_q        <= wdog_d;
            tx_data_q     <= tx_data_d;
            tx_wr_q       <= tx_wr_d;
            req_ready_q   <= req_ready_d;
            req_done_q    <= req_done_d;
            busy_q        <= busy_d;
            grant_id_q    <= grant_id_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_wr       = tx_wr_q;
    assign req_ready   = req_ready_q;
    assign req_done    = req_done_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_block_tx_arbiter.sv
// Bench for uart_block_tx_arbiter: transaction-level model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_uart_block_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 100;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*128-1:0] req_data = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_done;
    logic [127:0]        tx_data;
    logic                tx_wr;
    logic                tx_done = 1'b0;
    logic                busy;
    logic [2:0]          grant_id;
    logic                timeout_err;

    always #5 clk = ~clk;

    uart_block_tx_arbiter #(
        .NREQ(NREQ),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .req_done(req_done),
        .tx_data(tx_data),
        .tx_wr(tx_wr),
        .tx_done(tx_done),
        .busy(busy),
        .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Round-robin choice: first valid index after 'last', modulo NREQ.
    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Model: m_phase = -1 idle, 0 issue cycle, n = n-th cycle of waiting.
    int              m_phase = -1;
    int              m_last  = NREQ - 1;
    int              m_g     = 0;
    logic [127:0]    e_tx_data = '0;
    logic            e_tx_wr = 1'b0;
    logic [NREQ-1:0] e_ready = '0;
    logic [NREQ-1:0] e_done = '0;
    logic            e_busy = 1'b0;
    logic [2:0]      e_gid = '0;
    logic            e_to = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase   <= -1;
            m_last    <= NREQ - 1;
            m_g       <= 0;
            e_tx_data <= '0;
            e_tx_wr   <= 1'b0;
            e_ready   <= '0;
            e_done    <= '0;
            e_busy    <= 1'b0;
            e_gid     <= '0;
            e_to      <= 1'b0;
        end else begin
            e_tx_wr <= 1'b0;
            e_ready <= '0;
            e_done  <= '0;
            e_to    <= 1'b0;
            if (m_phase < 0) begin
                if (req_valid != '0) begin
                    m_g       <= pick(req_valid, m_last);
                    e_gid     <= 3'(pick(req_valid, m_last));
                    e_ready[pick(req_valid, m_last)] <= 1'b1;
                    e_tx_data <= req_data[pick(req_valid, m_last)*128 +: 128];
                    e_tx_wr   <= 1'b1;
                    e_busy    <= 1'b1;
                    m_phase   <= 0;
                end
            end else if (m_phase == 0) begin
                m_phase <= 1;
            end else if (tx_done) begin
                e_done[m_g] <= 1'b1;
                m_last      <= m_g;
                e_busy      <= 1'b0;
                m_phase     <= -1;
            end else if (TO != 0 && m_phase == TO) begin
                e_to    <= 1'b1;
                m_last  <= m_g;
                e_busy  <= 1'b0;
                m_phase <= -1;
            end else begin
                m_phase <= m_phase + 1;
            end
        end
    end

    // Compare all outputs against the model away from the active edge.
    always @(negedge clk) begin
        chk("m_tx_data", tx_data, e_tx_data);
        chk("m_tx_wr", 128'(tx_wr), 128'(e_tx_wr));
        chk("m_req_ready", 128'(req_ready), 128'(e_ready));
        chk("m_req_done", 128'(req_done), 128'(e_done));
        chk("m_busy", 128'(busy), 128'(e_busy));
        chk("m_grant_id", 128'(grant_id), 128'(e_gid));
        chk("m_timeout_err", 128'(timeout_err), 128'(e_to));
    end

    logic [2:0]   t2_seq [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [127:0] lit_a = 128'h00112233445566778899AABBCCDDEEFF;
    logic [127:0] lit_b = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
    int           cyc;
    int           n;
    bit           pend;
    int           cnt;
    int           r;

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_tx_wr", 128'(tx_wr), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_tx_data", tx_data, 128'(0));
        chk("rst_grant", 128'(grant_id), 128'(0));

        // T1: single request, done after 40 cycles
        rst = 1'b0;
        req_valid = 4'b0001;
        req_data[0 +: 128] = lit_a;
        tick();
        chk("t1_tx_wr", 128'(tx_wr), 128'(1));
        chk("t1_ready", 128'(req_ready), 128'(4'b0001));
        chk("t1_tx_data", tx_data, lit_a);
        req_valid = '0;
        repeat (39) tick();
        chk("t1_busy_wait", 128'(busy), 128'(1));
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("t1_done", 128'(req_done), 128'(4'b0001));
        chk("t1_busy", 128'(busy), 128'(0));
        tick();
        chk("t1_done_1cyc", 128'(req_done), 128'(0));

        // T2: all four valid after reset -> 0,1,2,3,0 with 2-cycle gaps
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[i*128 +: 128] = rand128();
        req_valid = 4'b1111;
        cyc = 0;
        for (int k = 0; k < 5; k++) begin
            while (!tx_wr && cyc < 20) begin
                tick();
                cyc++;
            end
            chk("t2_grant", 128'(grant_id), 128'(t2_seq[k]));
            if (k > 0) chk("t2_gap", 128'(cyc), 128'(2));
            tick();
            chk("t2_wr_1cyc", 128'(tx_wr), 128'(0));
            repeat (3) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            cyc = 1;
        end
        req_valid = '0;

        // T3: requester 2 times out, then 3 is served next
        req_valid = 4'b0100;
        req_data[2*128 +: 128] = rand128();
        tick();
        chk("t3_grant2", 128'(grant_id), 128'(2));
        req_data[2*128 +: 128] = rand128();
        req_data[3*128 +: 128] = rand128();
        req_valid = 4'b1100;
        tick();
        n = 0;
        while (busy && !timeout_err && n < 200) begin
            n++;
            tick();
        end
        chk("t3_wait_cycles", 128'(n), 128'(TO));
        chk("t3_timeout", 128'(timeout_err), 128'(1));
        chk("t3_no_done", 128'(req_done), 128'(0));
        tick();
        chk("t3_next_grant", 128'(grant_id), 128'(3));
        chk("t3_next_wr", 128'(tx_wr), 128'(1));
        req_valid = '0;
        repeat (4) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;

        // T4: tx_done in the same cycle the watchdog would expire
        req_valid = 4'b0001;
        req_data[0 +: 128] = rand128();
        tick();
        chk("t4_grant0", 128'(grant_id), 128'(0));
        req_valid = '0;
        repeat (TO) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("t4_done", 128'(req_done), 128'(4'b0001));
        chk("t4_no_timeout", 128'(timeout_err), 128'(0));
        tick();
        chk("t4_no_timeout2", 128'(timeout_err), 128'(0));

        // T5: asynchronous reset in the middle of WAIT
        req_valid = 4'b0010;
        req_data[128 +: 128] = rand128();
        tick();
        chk("t5_grant1", 128'(grant_id), 128'(1));
        req_valid = '0;
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_tx_data", tx_data, 128'(0));
        chk("t5_grant", 128'(grant_id), 128'(0));
        chk("t5_tx_wr", 128'(tx_wr), 128'(0));
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[i*128 +: 128] = rand128();
        req_valid = 4'b1111;
        tick();
        chk("t5_first_grant", 128'(grant_id), 128'(0));
        chk("t5_first_wr", 128'(tx_wr), 128'(1));
        req_valid = '0;
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("t5_done", 128'(req_done), 128'(4'b0001));

        // T6: spurious tx_done while idle; req_data churn during WAIT
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("t6_spur_done", 128'(req_done), 128'(0));
        chk("t6_spur_busy", 128'(busy), 128'(0));
        req_valid = 4'b0010;
        req_data[128 +: 128] = lit_b;
        tick();
        chk("t6_tx_data", tx_data, lit_b);
        req_valid = 4'b1000;
        req_data[128 +: 128] = rand128();
        req_data[3*128 +: 128] = rand128();
        repeat (10) tick();
        chk("t6_held", tx_data, lit_b);
        chk("t6_grant_held", 128'(grant_id), 128'(1));
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("t6_done", 128'(req_done), 128'(4'b0010));
        chk("t6_held_done", tx_data, lit_b);

        // Random traffic against the model
        pend = 1'b0;
        cnt  = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            tx_done = 1'b0;
            if (c == 2000) begin
                #2;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                pend = 1'b0;
            end
            if (tx_wr) begin
                r = $urandom_range(0, 9);
                if (r < 7) begin
                    pend = 1'b1;
                    cnt  = $urandom_range(1, 30);
                end else if (r == 7) begin
                    pend = 1'b1;
                    cnt  = TO;
                end else if (r == 8) begin
                    pend = 1'b1;
                    cnt  = TO + 1;
                end else begin
                    pend = 1'b0;
                end
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    tx_done = 1'b1;
                    pend    = 1'b0;
                end
            end else if ($urandom_range(0, 49) == 0) begin
                tx_done = 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    if ($urandom_range(0, 2) == 0) req_valid[i] = 1'b0;
                    else req_data[i*128 +: 128] = rand128();
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[i*128 +: 128] = rand128();
                    end
                end else if ($urandom_range(0, 99) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        tx_done = 1'b0;
        req_valid = '0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
